// File: rtl/csr_pkg.sv
// csr_pkg: shared definitions for the CSR pipeline unit.
//   CSR_OPCODE     : SYSTEM major opcode carrying Zicsr instructions.
//   F3_*           : funct3 encodings of the six Zicsr operations.
//   csr_op_e       : read-modify-write operation (funct3[1:0]).
//   PRIV_*         : privilege level encodings.
//   csr_stage_ctl_t: control part of an in-flight stage record {valid, we, addr}.
//                    The record's data field is XLEN-dependent and is appended
//                    by the user module.
package csr_pkg;

  localparam logic [6:0] CSR_OPCODE = 7'b1110011;

  localparam logic [2:0] F3_RW  = 3'b001;
  localparam logic [2:0] F3_RS  = 3'b010;
  localparam logic [2:0] F3_RC  = 3'b011;
  localparam logic [2:0] F3_RWI = 3'b101;
  localparam logic [2:0] F3_RSI = 3'b110;
  localparam logic [2:0] F3_RCI = 3'b111;

  localparam logic [1:0] PRIV_U = 2'd0;
  localparam logic [1:0] PRIV_S = 2'd1;
  localparam logic [1:0] PRIV_M = 2'd3;

  typedef enum logic [1:0] {
    CSR_OP_NONE = 2'b00,
    CSR_OP_RW   = 2'b01,
    CSR_OP_RS   = 2'b10,
    CSR_OP_RC   = 2'b11
  } csr_op_e;

  typedef struct packed {
    logic        valid;
    logic        we;
    logic [11:0] addr;
  } csr_stage_ctl_t;

endpackage

// File: rtl/csr_rmw_alu.sv
// csr_rmw_alu: combinational CSR read-modify-write datapath.
//   op      in  : csr_op_e operation (RW / RS / RC).
//   old_val in  : current CSR value (possibly forwarded).
//   src_val in  : rs1 value or zero-extended immediate.
//   new_val out : value to be written back to the CSR.
module csr_rmw_alu
  import csr_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  csr_op_e           op,
  input  logic [XLEN-1:0]   old_val,
  input  logic [XLEN-1:0]   src_val,
  output logic [XLEN-1:0]   new_val
);

  always_comb begin
    new_val = src_val;
    unique case (op)
      CSR_OP_RS: new_val = old_val | src_val;
      CSR_OP_RC: new_val = old_val & ~src_val;
      default:   new_val = src_val;
    endcase
  end

endmodule

// File: rtl/csr_pipe_unit.sv
// csr_pipe_unit: EX-stage Zicsr handler with an in-flight write pipeline.
//   Decodes CSR instructions, reads the CSR file combinationally (raddr_o /
//   rdata_i), computes the read-modify-write value and carries the pending
//   write FWD_DEPTH stages down to the commit port (wb_*). Checks privilege
//   and read-only legality.
// Ports:
//   clk, rst (sync, active-high), stall_i, flush_i (flush beats stall)
//   inst_valid_i, inst_i, rs1_val_i, priv_i : EX instruction and context
//   raddr_o / rdata_i                        : CSR file read port
//   rd_we_o, rd_data_o, illegal_o            : registered one cycle after accept
//   wb_valid_o, wb_addr_o, wb_data_o         : CSR file commit request
//   hazard_stall_o                           : upstream must hold the instruction
// Configuration macro: CSR_FWD_EN -- when defined, in-flight writes are
//   bypassed to younger readers and hazard_stall_o is tied low; otherwise
//   a reader of an address with a pending write is held until it commits.
module csr_pipe_unit
  import csr_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int FWD_DEPTH = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              inst_valid_i,
  input  logic [31:0]       inst_i,
  input  logic [XLEN-1:0]   rs1_val_i,
  input  logic [1:0]        priv_i,
  output logic [11:0]       raddr_o,
  input  logic [XLEN-1:0]   rdata_i,
  output logic              rd_we_o,
  output logic [XLEN-1:0]   rd_data_o,
  output logic              illegal_o,
  output logic              wb_valid_o,
  output logic [11:0]       wb_addr_o,
  output logic [XLEN-1:0]   wb_data_o,
  output logic              hazard_stall_o
);

  typedef struct packed {
    csr_stage_ctl_t        ctl;
    logic [XLEN-1:0]       data;
  } csr_stage_t;

  logic [2:0]       funct3;
  logic [4:0]       zimm;
  logic [4:0]       rd_idx;
  logic             is_csr;
  csr_op_e          op;
  logic [XLEN-1:0]  src_val;
  logic [XLEN-1:0]  old_val;
  logic [XLEN-1:0]  new_val;
  logic             we_req;
  logic             rd_en;
  logic             illegal;
  logic             take;
  logic [FWD_DEPTH:1] hit;

  csr_stage_t       stage_pn [1:FWD_DEPTH];
  logic             rd_we_p1;
  logic             illegal_p1;
  logic [XLEN-1:0]  rd_data_p1;

  // ---- p0: decode, operand select, legality (combinational, EX) ----
  assign funct3  = inst_i[14:12];
  assign zimm    = inst_i[19:15];
  assign rd_idx  = inst_i[11:7];
  assign raddr_o = inst_i[31:20];
  assign is_csr  = (inst_i[6:0] == CSR_OPCODE) && (funct3[1:0] != 2'b00);
  assign op      = csr_op_e'(funct3[1:0]);
  assign src_val = funct3[2] ? {{(XLEN-5){1'b0}}, zimm} : rs1_val_i;

  // Set/clear with a zero source is a pure read and must not write.
  assign we_req  = (op == CSR_OP_RW) || (zimm != 5'd0);
  assign rd_en   = !((op == CSR_OP_RW) && (rd_idx == 5'd0));
  assign illegal = is_csr && ((we_req && (raddr_o[11:10] == 2'b11)) ||
                              (priv_i < raddr_o[9:8]));

  always_comb begin
    hit = '0;
    for (int k = 1; k <= FWD_DEPTH; k++) begin
      hit[k] = stage_pn[k].ctl.valid && stage_pn[k].ctl.we &&
               (stage_pn[k].ctl.addr == raddr_o);
    end
  end

`ifdef CSR_FWD_EN
  // Scan oldest to youngest so the youngest matching write wins.
  always_comb begin
    old_val = rdata_i;
    for (int k = FWD_DEPTH; k >= 1; k--) begin
      if (hit[k]) old_val = stage_pn[k].data;
    end
  end
  assign hazard_stall_o = 1'b0;
`else
  assign old_val        = rdata_i;
  assign hazard_stall_o = inst_valid_i && is_csr && (|hit);
`endif

  assign take = inst_valid_i && !stall_i && !hazard_stall_o && is_csr;

  csr_rmw_alu #(.XLEN(XLEN)) u_alu (
    .op      (op),
    .old_val (old_val),
    .src_val (src_val),
    .new_val (new_val)
  );

  // ---- p1..pFWD_DEPTH: in-flight write stages, rd result in p1 ----
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 1; k <= FWD_DEPTH; k++) stage_pn[k] <= '0;
      rd_we_p1   <= 1'b0;
      illegal_p1 <= 1'b0;
      rd_data_p1 <= '0;
    end else if (flush_i) begin
      for (int k = 1; k <= FWD_DEPTH; k++) stage_pn[k].ctl <= '0;
      rd_we_p1   <= 1'b0;
      illegal_p1 <= 1'b0;
    end else if (!stall_i) begin
      stage_pn[1].ctl.valid <= take;
      stage_pn[1].ctl.we    <= take && we_req && !illegal;
      stage_pn[1].ctl.addr  <= raddr_o;
      stage_pn[1].data      <= new_val;
      for (int k = 2; k <= FWD_DEPTH; k++) stage_pn[k] <= stage_pn[k-1];
      rd_we_p1   <= take && rd_en && !illegal;
      illegal_p1 <= take && illegal;
      if (take) rd_data_p1 <= old_val;
    end
  end

  // ---- commit port: last stage ----
  assign rd_we_o    = rd_we_p1;
  assign illegal_o  = illegal_p1;
  assign rd_data_o  = rd_data_p1;
  assign wb_valid_o = stage_pn[FWD_DEPTH].ctl.valid && stage_pn[FWD_DEPTH].ctl.we;
  assign wb_addr_o  = stage_pn[FWD_DEPTH].ctl.addr;
  assign wb_data_o  = stage_pn[FWD_DEPTH].data;

endmodule

// File: tb/tb_csr_pipe_unit.sv
// tb_csr_pipe_unit: self-checking bench for csr_pipe_unit (XLEN=32, FWD_DEPTH=3).
// A behavioural model tracks the architectural CSR state, the committed CSR
// file state and a list of pending writes with their age in non-stalled cycles.
module tb_csr_pipe_unit;
  import csr_pkg::*;

  localparam int XLEN = 32;
  localparam int D    = 3;

  logic             clk = 1'b0;
  logic             rst, stall_i, flush_i, inst_valid_i;
  logic [31:0]      inst_i;
  logic [XLEN-1:0]  rs1_val_i;
  logic [1:0]       priv_i;
  logic [11:0]      raddr_o;
  logic [XLEN-1:0]  rdata_i;
  logic             rd_we_o, illegal_o, wb_valid_o, hazard_stall_o;
  logic [XLEN-1:0]  rd_data_o, wb_data_o;
  logic [11:0]      wb_addr_o;

  always #5 clk = ~clk;

  csr_pipe_unit #(.XLEN(XLEN), .FWD_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
    .inst_valid_i(inst_valid_i), .inst_i(inst_i), .rs1_val_i(rs1_val_i),
    .priv_i(priv_i), .raddr_o(raddr_o), .rdata_i(rdata_i),
    .rd_we_o(rd_we_o), .rd_data_o(rd_data_o), .illegal_o(illegal_o),
    .wb_valid_o(wb_valid_o), .wb_addr_o(wb_addr_o), .wb_data_o(wb_data_o),
    .hazard_stall_o(hazard_stall_o)
  );

  // CSR file seen by the DUT
  logic [XLEN-1:0] csr_file [4096];
  assign rdata_i = csr_file[raddr_o];
  always @(posedge clk) if (wb_valid_o) csr_file[wb_addr_o] <= wb_data_o;

  // Reference model
  typedef struct { logic [11:0] addr; logic [XLEN-1:0] data; int age; } pend_t;
  pend_t           pend_q[$];
  logic [XLEN-1:0] arch      [4096];
  logic [XLEN-1:0] committed [4096];
  logic            exp_rd_we, exp_ill, exp_chk_data;
  logic [XLEN-1:0] exp_rd_data;
  int              n_tests, n_fail;
  bit              chk_en;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] csr_inst(input logic [2:0] f3, input logic [11:0] a,
                                           input logic [4:0] s, input logic [4:0] d);
    return {a, s, f3, d, CSR_OPCODE};
  endfunction

  // One clock cycle: drive, check current outputs, advance the model, step.
  task automatic cyc(input logic v, input logic [31:0] inst, input logic [XLEN-1:0] rs1,
                     input logic [1:0] priv, input logic st, input logic fl,
                     input logic rs, output logic acc);
    logic [2:0] f3; logic [11:0] a; logic [4:0] z, rd;
    logic csr, hz, we, ill, wbv;
    logic [XLEN-1:0] src, old, nv;
    inst_valid_i = v; inst_i = inst; rs1_val_i = rs1; priv_i = priv;
    stall_i = st; flush_i = fl; rst = rs;
    #1;
    f3 = inst[14:12]; a = inst[31:20]; z = inst[19:15]; rd = inst[11:7];
    csr = (inst[6:0] == CSR_OPCODE) && (f3 != 3'd0) && (f3 != 3'd4);
    hz = 1'b0;
`ifndef CSR_FWD_EN
    if (v && csr) foreach (pend_q[i]) if (pend_q[i].addr == a) hz = 1'b1;
`endif
    wbv = (pend_q.size() > 0) && (pend_q[0].age == D);
    if (chk_en) begin
      chk("raddr", raddr_o, a);
      chk("rd_we", rd_we_o, exp_rd_we);
      chk("illegal", illegal_o, exp_ill);
      if (exp_chk_data) chk("rd_data", rd_data_o, exp_rd_data);
      chk("wb_valid", wb_valid_o, wbv);
      if (wbv) begin
        chk("wb_addr", wb_addr_o, pend_q[0].addr);
        chk("wb_data", wb_data_o, pend_q[0].data);
      end
      chk("hazard", hazard_stall_o, hz);
    end
    if (wbv) committed[pend_q[0].addr] = pend_q[0].data;
    acc = 1'b0;
    if (rs || fl) begin
      pend_q.delete();
      foreach (arch[i]) arch[i] = committed[i];
      exp_rd_we = 1'b0; exp_ill = 1'b0;
      if (rs) begin exp_rd_data = '0; exp_chk_data = 1'b1; end
    end else if (!st) begin
      foreach (pend_q[i]) pend_q[i].age++;
      if (pend_q.size() > 0 && pend_q[0].age > D) void'(pend_q.pop_front());
      acc = v && !hz;
      exp_rd_we = 1'b0; exp_ill = 1'b0;
      if (acc && csr) begin
        src = f3[2] ? XLEN'(z) : rs1;
        old = arch[a];
        case (f3[1:0])
          2'd1:    nv = src;
          2'd2:    nv = old | src;
          default: nv = old & ~src;
        endcase
        we  = (f3[1:0] == 2'd1) || (z != 5'd0);
        ill = (we && a[11:10] == 2'b11) || (priv < a[9:8]);
        exp_ill      = ill;
        exp_rd_we    = !ill && !(f3[1:0] == 2'd1 && rd == 5'd0);
        exp_rd_data  = old;
        exp_chk_data = 1'b1;
        if (we && !ill) begin
          pend_q.push_back('{a, nv, 1});
          arch[a] = nv;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) cyc(1'b0, 32'h0, '0, PRIV_M, 1'b0, 1'b0, 1'b0, acc);
  endtask

  task automatic issue(input logic [31:0] inst, input logic [XLEN-1:0] rs1,
                       input logic [1:0] priv, output int waits);
    logic acc;
    waits = 0;
    do begin
      cyc(1'b1, inst, rs1, priv, 1'b0, 1'b0, 1'b0, acc);
      if (!acc) waits++;
    end while (!acc && waits < 20);
    if (!acc) begin
      n_tests++; n_fail++;
      $display("FAIL issue_timeout observed=not accepted expected=accepted");
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic acc;
    int w, seen;
    logic [11:0] addr_tab [6];
    logic [2:0]  f3_tab   [6];
    logic [1:0]  priv_tab [4];
    addr_tab = '{12'h340, 12'h300, 12'h305, 12'hC00, 12'h100, 12'h040};
    f3_tab   = '{F3_RW, F3_RS, F3_RC, F3_RWI, F3_RSI, F3_RCI};
    priv_tab = '{PRIV_U, PRIV_S, PRIV_M, PRIV_M};
    n_tests = 0; n_fail = 0; chk_en = 0;
    exp_rd_we = 0; exp_ill = 0; exp_chk_data = 0; exp_rd_data = '0;
    for (int i = 0; i < 4096; i++) csr_file[i] = 32'(i) * 32'h9E3779B1;
    csr_file[12'h340] = 32'h11;
    csr_file[12'h300] = 32'h0;
    csr_file[12'h305] = 32'h1000;
    csr_file[12'hC00] = 32'hC0FFEE00;
    foreach (csr_file[i]) begin committed[i] = csr_file[i]; arch[i] = csr_file[i]; end

    // Reset
    cyc(1'b0, 32'h0, '0, PRIV_M, 1'b0, 1'b0, 1'b1, acc);
    cyc(1'b0, 32'h0, '0, PRIV_M, 1'b0, 1'b0, 1'b1, acc);
    chk_en = 1;
    chk("reset_wb_addr", wb_addr_o, 12'h0);
    chk("reset_wb_data", wb_data_o, 32'h0);

    // CSRRW 0x340
    issue(csr_inst(F3_RW, 12'h340, 5'd1, 5'd2), 32'hDEADBEEF, PRIV_M, w);
    chk("rw_rd_data", rd_data_o, 32'h11);
    chk("rw_rd_we", rd_we_o, 1'b1);
    idle(2);
    chk("rw_wb_valid", wb_valid_o, 1'b1);
    chk("rw_wb_addr", wb_addr_o, 12'h340);
    chk("rw_wb_data", wb_data_o, 32'hDEADBEEF);
    idle(2);

    // Back-to-back dependent CSRRS
    issue(csr_inst(F3_RS, 12'h300, 5'd1, 5'd3), 32'h8, PRIV_M, w);
    issue(csr_inst(F3_RS, 12'h300, 5'd2, 5'd3), 32'h80, PRIV_M, w);
`ifdef CSR_FWD_EN
    chk("dep_hazard_cycles", w, 0);
`else
    chk("dep_hazard_cycles", w, D);
`endif
    chk("dep_rd_data", rd_data_o, 32'h8);
    idle(2);
    chk("dep_wb_data", wb_data_o, 32'h88);
    idle(3);

    // Read-only CSR and privilege
    issue(csr_inst(F3_RS, 12'hC00, 5'd0, 5'd5), 32'h0, PRIV_M, w);
    chk("ro_read_data", rd_data_o, 32'hC0FFEE00);
    chk("ro_read_illegal", illegal_o, 1'b0);
    idle(2);
    chk("ro_read_no_wb", wb_valid_o, 1'b0);
    issue(csr_inst(F3_RW, 12'hC00, 5'd1, 5'd5), 32'h5, PRIV_M, w);
    chk("ro_write_illegal", illegal_o, 1'b1);
    chk("ro_write_rd_we", rd_we_o, 1'b0);
    issue(csr_inst(F3_RS, 12'h300, 5'd0, 5'd6), 32'h0, PRIV_U, w);
    chk("priv_illegal", illegal_o, 1'b1);
    idle(3);

    // Flush (with simultaneous stall) kills the in-flight write
    issue(csr_inst(F3_RW, 12'h340, 5'd3, 5'd1), 32'h12345678, PRIV_M, w);
    cyc(1'b1, csr_inst(F3_RW, 12'h305, 5'd4, 5'd1), 32'h55, PRIV_M, 1'b1, 1'b1, 1'b0, acc);
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (wb_valid_o) seen++;
      idle(1);
    end
    chk("flush_no_wb", seen, 0);

    // Stall freezes outputs, wb request repeats
    issue(csr_inst(F3_RW, 12'h305, 5'd7, 5'd4), 32'hA5A5A5A5, PRIV_M, w);
    for (int i = 0; i < 3; i++)
      cyc(1'b1, csr_inst(F3_RS, 12'h340, 5'd1, 5'd1), 32'h1, PRIV_M, 1'b1, 1'b0, 1'b0, acc);
    chk("stall_rd_we", rd_we_o, 1'b1);
    chk("stall_rd_data", rd_data_o, 32'h1000);
    chk("stall_wb_idle", wb_valid_o, 1'b0);
    idle(2);
    for (int i = 0; i < 2; i++)
      cyc(1'b0, 32'h0, '0, PRIV_M, 1'b1, 1'b0, 1'b0, acc);
    chk("stall_wb_held", wb_valid_o, 1'b1);
    chk("stall_wb_data", wb_data_o, 32'hA5A5A5A5);
    idle(1);
    chk("stall_wb_done", wb_valid_o, 1'b0);

    // Reset with two writes in flight
    issue(csr_inst(F3_RW, 12'h340, 5'd1, 5'd1), 32'h1111, PRIV_M, w);
    issue(csr_inst(F3_RW, 12'h305, 5'd2, 5'd1), 32'h2222, PRIV_M, w);
    cyc(1'b0, 32'h0, '0, PRIV_M, 1'b0, 1'b0, 1'b1, acc);
    cyc(1'b0, 32'h0, '0, PRIV_M, 1'b0, 1'b0, 1'b1, acc);
    chk("rst_rd_we", rd_we_o, 1'b0);
    chk("rst_rd_data", rd_data_o, 32'h0);
    chk("rst_illegal", illegal_o, 1'b0);
    chk("rst_wb_addr", wb_addr_o, 12'h0);
    chk("rst_wb_data", wb_data_o, 32'h0);
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (wb_valid_o) seen++;
      idle(1);
    end
    chk("rst_no_wb", seen, 0);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      logic [31:0] inst;
      logic [4:0]  z, rd;
      z  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      rd = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      inst = csr_inst(f3_tab[$urandom_range(0, 5)], addr_tab[$urandom_range(0, 5)], z, rd);
      if ($urandom_range(0, 9) == 0) inst[6:0] = 7'h33;
      cyc(($urandom_range(0, 4) != 0), inst, $urandom(), priv_tab[$urandom_range(0, 3)],
          ($urandom_range(0, 9) == 0), ($urandom_range(0, 29) == 0), 1'b0, acc);
    end
    idle(5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
